// File: rtl/wfg_interconnect_core.sv
`default_nettype none
// ============================================================================
// wfg_interconnect_core : routes two stimulus streams onto two driver streams
// through one-entry output registers, with broadcast and deferred re-select.
// Revision: 1.0
// ============================================================================
module wfg_interconnect_core #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_en_q_i,
  input  logic [1:0]       driver0_select_q_i,
  input  logic [1:0]       driver1_select_q_i,
  input  logic [DATAW-1:0] stimulus_0_tdata_i,
  input  logic             stimulus_0_tvalid_i,
  output logic             stimulus_0_tready_o,
  input  logic [DATAW-1:0] stimulus_1_tdata_i,
  input  logic             stimulus_1_tvalid_i,
  output logic             stimulus_1_tready_o,
  output logic [DATAW-1:0] driver_0_tdata_o,
  output logic             driver_0_tvalid_o,
  input  logic             driver_0_tready_i,
  output logic [DATAW-1:0] driver_1_tdata_o,
  output logic             driver_1_tvalid_o,
  input  logic             driver_1_tready_i
);

  localparam logic [0:0] c_S_DISABLED = 1'b0;
  localparam logic [0:0] c_S_RUN      = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic                  w_run;
  logic [1:0][1:0]       w_select_q;
  logic [1:0][1:0]       w_sel;
  logic [1:0][DATAW-1:0] w_stim_data;
  logic [1:0]            w_stim_valid;
  logic [1:0]            w_stim_ready;
  logic [1:0]            w_drv_ready;
  logic [1:0]            w_drv_valid;
  logic [1:0][DATAW-1:0] w_drv_data;
  logic [1:0]            w_can_load;
  logic [1:0]            w_load;

  assign w_select_q   = {driver1_select_q_i, driver0_select_q_i};
  assign w_stim_data  = {stimulus_1_tdata_i, stimulus_0_tdata_i};
  assign w_stim_valid = {stimulus_1_tvalid_i, stimulus_0_tvalid_i};
  assign w_drv_ready  = {driver_1_tready_i, driver_0_tready_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_DISABLED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_DISABLED: if (ctrl_en_q_i)  w_state_next = c_S_RUN;
      c_S_RUN:      if (!ctrl_en_q_i) w_state_next = c_S_DISABLED;
      default:      w_state_next = c_S_DISABLED;
    endcase
  end

  always_comb begin
    w_run = (r_state == c_S_RUN);
  end

  // A stimulus is accepted only when every driver mapped to it can take the sample.
  for (genvar s = 0; s < 2; s++) begin : g_stim
    logic [1:0] w_hit;
    for (genvar d = 0; d < 2; d++) begin : g_hit
      assign w_hit[d] = (w_sel[d] == 2'(s));
    end
    assign w_stim_ready[s] = w_run && (|w_hit) && (&(~w_hit | w_can_load));
  end

  for (genvar d = 0; d < 2; d++) begin : g_drv
    logic [1:0]       r_sel;
    logic             r_valid;
    logic [DATAW-1:0] r_data;

    assign w_sel[d]       = r_sel;
    assign w_drv_valid[d] = r_valid;
    assign w_drv_data[d]  = r_data;
    assign w_can_load[d]  = !r_valid || w_drv_ready[d];
    assign w_load[d]      = w_run && !r_sel[1] &&
                            w_stim_valid[r_sel[0]] && w_stim_ready[r_sel[0]];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sel   <= '0;
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (!w_run) begin
        r_sel   <= w_select_q[d];
        r_valid <= 1'b0;
      end else begin
        if (w_load[d]) begin
          r_valid <= 1'b1;
          r_data  <= w_stim_data[r_sel[0]];
        end else if (w_drv_ready[d]) begin
          r_valid <= 1'b0;
        end
        // Re-select only while idle so a held sample is never re-routed.
        if (!r_valid && !w_load[d]) begin
          r_sel <= w_select_q[d];
        end
      end
    end
  end

  assign stimulus_0_tready_o = w_stim_ready[0];
  assign stimulus_1_tready_o = w_stim_ready[1];
  assign driver_0_tdata_o    = w_drv_data[0];
  assign driver_0_tvalid_o   = w_drv_valid[0];
  assign driver_1_tdata_o    = w_drv_data[1];
  assign driver_1_tvalid_o   = w_drv_valid[1];

endmodule
`default_nettype wire

// File: tb/tb_wfg_interconnect_core.sv
`default_nettype none
// Self-checking bench for wfg_interconnect_core: directed scenarios plus a
// randomized run against a behavioural model of the routing rules.
module tb_wfg_interconnect_core;
  localparam int DATAW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       dsel   [2];
  logic [DATAW-1:0] sdata  [2];
  logic             svalid [2];
  logic             sready [2];
  logic [DATAW-1:0] ddata  [2];
  logic             dvalid [2];
  logic             dready [2];

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic             m_run;
  logic [1:0]       m_sel   [2];
  logic             m_valid [2];
  logic [DATAW-1:0] m_data  [2];

  always #5 clk = ~clk;

  wfg_interconnect_core #(.DATAW(DATAW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ctrl_en_q_i         (en),
    .driver0_select_q_i  (dsel[0]),
    .driver1_select_q_i  (dsel[1]),
    .stimulus_0_tdata_i  (sdata[0]),
    .stimulus_0_tvalid_i (svalid[0]),
    .stimulus_0_tready_o (sready[0]),
    .stimulus_1_tdata_i  (sdata[1]),
    .stimulus_1_tvalid_i (svalid[1]),
    .stimulus_1_tready_o (sready[1]),
    .driver_0_tdata_o    (ddata[0]),
    .driver_0_tvalid_o   (dvalid[0]),
    .driver_0_tready_i   (dready[0]),
    .driver_1_tdata_o    (ddata[1]),
    .driver_1_tvalid_o   (dvalid[1]),
    .driver_1_tready_i   (dready[1])
  );

  // A stimulus may go only when running, someone maps it, and all mappers can take it.
  function automatic logic m_tready(int s);
    logic any;
    logic ok;
    any = 1'b0;
    ok  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (m_sel[d] == 2'(s)) begin
        any = 1'b1;
        if (m_valid[d] && !dready[d]) ok = 1'b0;
      end
    end
    return m_run && any && ok;
  endfunction

  function automatic void m_reset();
    m_run = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_sel[d]   = 2'd0;
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
    end
  endfunction

  function automatic void m_advance();
    logic             t  [2];
    logic             nv [2];
    logic [1:0]       ns [2];
    logic [DATAW-1:0] nd [2];
    logic             ld;
    int               src;
    if (!rst_n) begin
      m_reset();
      return;
    end
    for (int s = 0; s < 2; s++) t[s] = m_tready(s);
    for (int d = 0; d < 2; d++) begin
      nv[d] = m_valid[d];
      ns[d] = m_sel[d];
      nd[d] = m_data[d];
      if (!m_run) begin
        nv[d] = 1'b0;
        ns[d] = dsel[d];
      end else begin
        ld  = 1'b0;
        src = int'(m_sel[d]);
        if (src < 2) ld = svalid[src] && t[src];
        if (ld) begin
          nv[d] = 1'b1;
          nd[d] = sdata[src];
        end else if (dready[d]) begin
          nv[d] = 1'b0;
        end
        if (!m_valid[d] && !ld) ns[d] = dsel[d];
      end
    end
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = nv[d];
      m_sel[d]   = ns[d];
      m_data[d]  = nd[d];
    end
    m_run = en;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_advance();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dvalid[d] !== 1'b0 || ddata[d] !== '0) begin
        failures++;
        $display("FAIL reset_drv%0d valid=%b data=%h expected 0/0", d, dvalid[d], ddata[d]);
      end
      checks++;
      if (sready[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_stim%0d tready=%b expected 0", d, sready[d]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_route();
    en = 1'b1; dsel[0] = 2'd0; dsel[1] = 2'd1;
    dready[0] = 1'b1; dready[1] = 1'b1;
    tick();
    sdata[0] = 32'hA5A5_0001; svalid[0] = 1'b1;
    sdata[1] = 32'h0000_00FF; svalid[1] = 1'b1;
    #1;
    checks++;
    if (sready[0] !== 1'b1 || sready[1] !== 1'b1) begin
      failures++;
      $display("FAIL basic_tready got %b%b expected 11", sready[1], sready[0]);
    end
    tick();
    svalid[0] = 1'b0; svalid[1] = 1'b0;
    #1;
    checks++;
    if (dvalid[0] !== 1'b1 || ddata[0] !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL basic_drv0 valid=%b data=%h expected 1/a5a50001", dvalid[0], ddata[0]);
    end
    checks++;
    if (dvalid[1] !== 1'b1 || ddata[1] !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL basic_drv1 valid=%b data=%h expected 1/000000ff", dvalid[1], ddata[1]);
    end
    tick();
    #1;
    checks++;
    if (dvalid[0] !== 1'b0 || dvalid[1] !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain valid=%b%b expected 00", dvalid[1], dvalid[0]);
    end
  endtask

  task automatic test_broadcast_backpressure();
    dsel[0] = 2'd0; dsel[1] = 2'd0;
    tick();
    sdata[0] = 32'h1111_0001; svalid[0] = 1'b1;
    #1;
    checks++;
    if (sready[0] !== 1'b1) begin
      failures++;
      $display("FAIL bcast_first_tready got %b expected 1", sready[0]);
    end
    tick();
    sdata[0] = 32'h1111_0002; dready[1] = 1'b0;
    #1;
    checks++;
    if (sready[0] !== 1'b0) begin
      failures++;
      $display("FAIL bcast_held_tready got %b expected 0", sready[0]);
    end
    tick();
    #1;
    checks++;
    if (dvalid[0] !== 1'b0 || dvalid[1] !== 1'b1 || ddata[1] !== 32'h1111_0001) begin
      failures++;
      $display("FAIL bcast_hold v0=%b v1=%b d1=%h expected 0/1/11110001", dvalid[0], dvalid[1], ddata[1]);
    end
    dready[1] = 1'b1;
    #1;
    checks++;
    if (sready[0] !== 1'b1) begin
      failures++;
      $display("FAIL bcast_release_tready got %b expected 1", sready[0]);
    end
    tick();
    svalid[0] = 1'b0;
    #1;
    checks++;
    if (dvalid[0] !== 1'b1 || ddata[0] !== 32'h1111_0002 ||
        dvalid[1] !== 1'b1 || ddata[1] !== 32'h1111_0002) begin
      failures++;
      $display("FAIL bcast_second d0=%b/%h d1=%b/%h expected 1/11110002 both",
               dvalid[0], ddata[0], dvalid[1], ddata[1]);
    end
    tick();
  endtask

  task automatic test_deferred_select();
    dready[0] = 1'b0;
    sdata[0] = 32'h0000_1234; svalid[0] = 1'b1;
    tick();
    svalid[0] = 1'b0;
    dsel[0] = 2'd1; dsel[1] = 2'd3;
    sdata[1] = 32'h0000_BEEF; svalid[1] = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (dvalid[0] !== 1'b1 || ddata[0] !== 32'h0000_1234 || sready[1] !== 1'b0) begin
      failures++;
      $display("FAIL defer_hold v=%b d=%h rdy1=%b expected 1/00001234/0", dvalid[0], ddata[0], sready[1]);
    end
    dready[0] = 1'b1;
    tick();
    #1;
    checks++;
    if (dvalid[0] !== 1'b0) begin
      failures++;
      $display("FAIL defer_fall valid=%b expected 0", dvalid[0]);
    end
    tick();
    #1;
    checks++;
    if (sready[1] !== 1'b1) begin
      failures++;
      $display("FAIL defer_switch tready1=%b expected 1", sready[1]);
    end
    tick();
    svalid[1] = 1'b0;
    #1;
    checks++;
    if (dvalid[0] !== 1'b1 || ddata[0] !== 32'h0000_BEEF) begin
      failures++;
      $display("FAIL defer_new v=%b d=%h expected 1/0000beef", dvalid[0], ddata[0]);
    end
    tick();
  endtask

  task automatic test_disable_flush();
    dready[0] = 1'b0;
    sdata[1] = 32'h5555_0001; svalid[1] = 1'b1;
    tick();
    svalid[1] = 1'b0;
    en = 1'b0;
    tick();
    sdata[1] = 32'h5555_0002; svalid[1] = 1'b1;
    #1;
    checks++;
    if (sready[0] !== 1'b0 || sready[1] !== 1'b0) begin
      failures++;
      $display("FAIL flush_tready got %b%b expected 00", sready[1], sready[0]);
    end
    tick();
    #1;
    checks++;
    if (dvalid[0] !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid got %b expected 0", dvalid[0]);
    end
    en = 1'b1;
    tick();
    sdata[1] = 32'h5555_0003; dready[0] = 1'b1;
    tick();
    svalid[1] = 1'b0;
    #1;
    checks++;
    if (dvalid[0] !== 1'b1 || ddata[0] !== 32'h5555_0003) begin
      failures++;
      $display("FAIL flush_resume v=%b d=%h expected 1/55550003", dvalid[0], ddata[0]);
    end
    tick();
  endtask

  task automatic test_unmapped();
    dsel[0] = 2'd3; dsel[1] = 2'd3;
    tick();
    sdata[0] = 32'hDEAD_0000; svalid[0] = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (sready[0] !== 1'b0 || dvalid[0] !== 1'b0 || dvalid[1] !== 1'b0) begin
      failures++;
      $display("FAIL unmapped rdy0=%b v0=%b v1=%b expected 0/0/0", sready[0], dvalid[0], dvalid[1]);
    end
    svalid[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream();
    int k;
    int run_cnt;
    logic hs;
    k = 1;
    run_cnt = 0;
    dsel[0] = 2'd0; dsel[1] = 2'd1;
    dready[0] = 1'b1; dready[1] = 1'b1;
    svalid[0] = 1'b1; svalid[1] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      sdata[0] = 32'h7700_0000 + k;
      if (i == 6) begin
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (dvalid[0] !== 1'b0 || ddata[0] !== '0 || sready[0] !== 1'b0) begin
          failures++;
          $display("FAIL midrst_zero v=%b d=%h rdy=%b expected 0/0/0", dvalid[0], ddata[0], sready[0]);
        end
      end else begin
        rst_n = 1'b1;
        #1;
      end
      checks++;
      if (dvalid[0] !== m_valid[0] || ddata[0] !== m_data[0] || sready[0] !== m_tready(0)) begin
        failures++;
        $display("FAIL midrst_cyc%0d v=%b d=%h rdy=%b expected %b/%h/%b",
                 i, dvalid[0], ddata[0], sready[0], m_valid[0], m_data[0], m_tready(0));
      end
      if (i >= 16 && dvalid[0] === 1'b1) run_cnt++;
      hs = sready[0];
      tick();
      if (hs) k++;
    end
    checks++;
    if (run_cnt != 8) begin
      failures++;
      $display("FAIL midrst_throughput got %0d valid cycles expected 8", run_cnt);
    end
    svalid[0] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 29) == 0) en = ~en;
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 7) == 0) dsel[j] = 2'($urandom_range(0, 3));
        sdata[j]  = $urandom;
        svalid[j] = ($urandom_range(0, 3) != 0);
        dready[j] = ($urandom_range(0, 2) != 0);
      end
      if (!rst_n) m_reset();
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (dvalid[d] !== m_valid[d] || ddata[d] !== m_data[d]) begin
          failures++;
          $display("FAIL rand_drv%0d cyc=%0d v=%b d=%h expected %b/%h",
                   d, i, dvalid[d], ddata[d], m_valid[d], m_data[d]);
        end
        checks++;
        if (sready[d] !== m_tready(d)) begin
          failures++;
          $display("FAIL rand_stim%0d cyc=%0d tready=%b expected %b", d, i, sready[d], m_tready(d));
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    for (int j = 0; j < 2; j++) begin
      dsel[j] = 2'd0; sdata[j] = '0; svalid[j] = 1'b0; dready[j] = 1'b0;
    end
    m_reset();
    @(negedge clk);
    test_reset();
    test_basic_route();
    test_broadcast_backpressure();
    test_deferred_select();
    test_disable_flush();
    test_unmapped();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
